// File: rtl/s27_bist_ctrl.sv
// s27_bist_ctrl: LFSR stimulus, CUT reset sequencing and SISR signature compaction for the s27 CUT.
module s27_bist_ctrl #(
  parameter int          NUM_PATTERNS = 16,
  parameter logic [3:0]  SEED         = 4'b0001,
  parameter int          INIT_CYCLES  = 2,
  parameter logic [15:0] GOLDEN_SIG   = 16'h0000
) (
  input  logic        CK,
  input  logic        reset,
  input  logic        start,
  input  logic        cut_out,
  output logic [3:0]  cut_in,
  output logic        cut_reset,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic [15:0] signature
);
  typedef enum logic [1:0] {IDLE, INIT, RUN, DONE} state_t;
  localparam logic [3:0]  INIT_LAST = 4'(INIT_CYCLES - 1);
  localparam logic [15:0] PAT_LAST  = 16'(NUM_PATTERNS - 1);
  state_t      state_q, state_d;
  logic [3:0]  lfsr_q, lfsr_d, lfsr_nx, cut_in_q, cut_in_d, icnt_q, icnt_d;
  logic [15:0] pcnt_q, pcnt_d, sig_q, sig_d, sig_step;
  logic        cut_reset_q, cut_reset_d, busy_q, busy_d, done_q, done_d, pass_q, pass_d;
  logic        init_last, run_last;
  assign sig_step  = {sig_q[14:0], 1'b0} ^ (sig_q[15] ? 16'h1021 : 16'h0) ^ {15'b0, cut_out};
  assign lfsr_nx   = {lfsr_q[2:0], lfsr_q[3] ^ lfsr_q[0]};
  assign init_last = icnt_q == INIT_LAST;
  assign run_last  = pcnt_q == PAT_LAST;
  always_ff @(posedge CK or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      lfsr_q      <= SEED;
      cut_in_q    <= '0;
      icnt_q      <= '0;
      pcnt_q      <= '0;
      sig_q       <= '0;
      cut_reset_q <= 1'b1;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      lfsr_q      <= lfsr_d;
      cut_in_q    <= cut_in_d;
      icnt_q      <= icnt_d;
      pcnt_q      <= pcnt_d;
      sig_q       <= sig_d;
      cut_reset_q <= cut_reset_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      pass_q      <= pass_d;
    end
  end
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, DONE: state_d = start ? INIT : state_q;
      INIT:       state_d = init_last ? RUN : INIT;
      RUN:        state_d = run_last ? DONE : RUN;
      default:    state_d = IDLE;
    endcase
  end
  // Outputs are registered: this process computes their next values alongside the datapath.
  always_comb begin
    lfsr_d      = lfsr_q;
    cut_in_d    = cut_in_q;
    icnt_d      = icnt_q;
    pcnt_d      = pcnt_q;
    sig_d       = sig_q;
    cut_reset_d = cut_reset_q;
    busy_d      = busy_q;
    done_d      = done_q;
    pass_d      = pass_q;
    case (state_q)
      IDLE, DONE: if (start) begin
        icnt_d      = '0;
        lfsr_d      = SEED;
        sig_d       = '0;
        cut_in_d    = SEED;
        cut_reset_d = 1'b1;
        busy_d      = 1'b1;
        done_d      = 1'b0;
        pass_d      = 1'b0;
      end
      INIT: begin
        icnt_d = icnt_q + 4'd1;
        if (init_last) begin
          cut_reset_d = 1'b0;
          pcnt_d      = '0;
        end
      end
      RUN: begin
        sig_d    = sig_step;
        lfsr_d   = lfsr_nx;
        cut_in_d = lfsr_nx;
        pcnt_d   = pcnt_q + 16'd1;
        if (run_last) begin
          pass_d      = sig_step == GOLDEN_SIG;
          done_d      = 1'b1;
          busy_d      = 1'b0;
          cut_reset_d = 1'b1;
          cut_in_d    = '0;
        end
      end
      default: ;
    endcase
  end
  assign cut_in    = cut_in_q;
  assign cut_reset = cut_reset_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign pass      = pass_q;
  assign signature = sig_q;
endmodule

// File: doc/s27_bist_ctrl.md
Name: s27_bist_ctrl

Overview:
Built-in self-test controller for the s27 circuit-under-test (CUT). It drives the CUT primary inputs G0..G3 from a 4-bit maximal LFSR and controls the CUT synchronous reset. It compacts the CUT output G17 into a 16-bit serial signature register (SISR) and compares the final signature against a golden value. It sits beside the CUT in the Trojan-detection harness: it is the stimulus source and response observer for the s27 interface.

Parameters:
NUM_PATTERNS, 16, number of patterns applied and sampled per run (legal range 1..65535)
SEED, 4'b0001, LFSR start value (must be nonzero)
INIT_CYCLES, 2, cycles the CUT reset is held before patterns start (legal range 1..15)
GOLDEN_SIG, 16'h0000, expected final signature

Ports:
CK  input  1  clock, rising edge
reset  input  1  asynchronous, active-high; clears all state
start  input  1  one-cycle pulse; begins a run from IDLE or DONE
cut_out  input  1  CUT output G17
cut_in  output  4  CUT inputs; bit0=G0, bit1=G1, bit2=G2, bit3=G3
cut_reset  output  1  drives the CUT synchronous reset
busy  output  1  high in INIT and RUN
done  output  1  high in DONE
pass  output  1  valid when done=1; 1 if signature==GOLDEN_SIG
signature  output  16  current SISR contents

Behaviour:
- All outputs are registered. Reset values: state=IDLE, cut_in=0, cut_reset=1, busy=0, done=0, pass=0, signature=0, LFSR=SEED, pattern count=0, init count=0.
- FSM states: IDLE, INIT, RUN, DONE.
- IDLE: cut_reset=1. On start=1, go to INIT. On entry to INIT: init count=0, LFSR=SEED, signature=0, cut_in=SEED.
- INIT: cut_reset=1, cut_in=SEED, and the CUT is clocked in reset for exactly INIT_CYCLES cycles. After those cycles, go to RUN with cut_reset=0 and pattern count=0.
- RUN: pattern k (k=0..N-1) is held on cut_in for exactly one cycle; pattern 0 is SEED.
- Every RUN edge does three things:
  - signature <= {signature[14:0],1'b0} ^ (signature[15] ? 16'h1021 : 16'h0) ^ {15'b0,cut_out}
  - LFSR <= {LFSR[2:0], LFSR[3]^LFSR[0]}, and cut_in takes the new LFSR value
  - pattern count increments
- cut_out is sampled at the edge that ends the cycle in which pattern k is applied. The CUT path is combinational from its inputs and state, so the sample reflects pattern k.
- LFSR sequence from 0001: 0001, 0011, 0111, 1111, 1110, 1101, 1010, 0101, 1011, 0110, 1100, 1001, 0010, 0100, 1000, then repeats 0001. Period is 15; the sequence wraps freely when NUM_PATTERNS > 15.
- After the NUM_PATTERNS-th sample, go to DONE. In the same edge:
  - pass <= (updated signature == GOLDEN_SIG)
  - done <= 1, busy <= 0
  - cut_reset <= 1, cut_in <= 0
- DONE: signature, pass and done hold until start or reset. start in DONE behaves as start in IDLE: done and pass clear on entry to INIT.
- start while busy=1 is ignored. A start pulse on the same edge that enters DONE is ignored.
- Asynchronous reset mid-run aborts immediately to the reset values. No partial result is reported.
- No combinational path from any input to any output.

Test Plan:
- Reset, then start with SEED=0001 -> cut_reset=1 for exactly INIT_CYCLES=2 cycles with cut_in=0001. Then cut_in steps through 0001, 0011, 0111, 1111 ... 1000, 0001 (15-cycle wrap visible with NUM_PATTERNS=16). done rises exactly INIT_CYCLES+NUM_PATTERNS cycles after the start edge.
- cut_out tied 0, GOLDEN_SIG=16'h0000, NUM_PATTERNS=16 -> signature=16'h0000, pass=1, done=1.
- NUM_PATTERNS=4, cut_out=1 only on the pattern-0 sample, then 0 -> signature=16'h0008; GOLDEN_SIG=16'h0008 gives pass=1, GOLDEN_SIG=16'h0009 gives pass=0.
- CUT connected, golden from a fault-free bench model -> pass=1. Force cut_out stuck-at-1 -> signature differs from golden, pass=0.
- start pulsed during INIT and again mid-RUN -> no restart; pattern sequence and done timing are unchanged.
- reset asserted asynchronously mid-RUN (between edges) -> outputs return to reset values immediately. A following start reruns from SEED and gives the same signature as an uninterrupted run.
